// File: rtl/uart_rx_cmd_ctrl_if.sv
// uart_rx_cmd_ctrl_if: byte-receive, register-bus and transmit-response signals of the command sequencer.
interface uart_rx_cmd_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [7:0] reg_rdata;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       frame_ok;
    logic       err_chk;
    logic       err_timeout;
    logic       err_ovr;
    modport slave (
        input  rx_data, rx_done, reg_rdata, tx_busy,
        output reg_addr, reg_wdata, reg_wr_en, reg_rd_en, tx_data, tx_start,
               frame_ok, err_chk, err_timeout, err_ovr
    );
    modport master (
        output rx_data, rx_done, reg_rdata, tx_busy,
        input  reg_addr, reg_wdata, reg_wr_en, reg_rd_en, tx_data, tx_start,
               frame_ok, err_chk, err_timeout, err_ovr
    );
endinterface

// File: rtl/uart_rx_cmd_ctrl.sv
// uart_rx_cmd_ctrl: frames received bytes into SYNC/CMD/ADDR/DATA/CHK commands, drives the register bus
// and hands a one-byte response (ACK, read data or NAK) to the transmitter.
module uart_rx_cmd_ctrl #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [7:0]  CMD_WR         = 8'h01,
    parameter logic [7:0]  CMD_RD         = 8'h02,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15,
    parameter int unsigned TIMEOUT_CYCLES = 250_000
) (
    input logic               clk,
    input logic               reset,
    uart_rx_cmd_ctrl_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [2:0] {IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, EXEC, RD_WAIT, SEND} state_t;
    state_t        r_state, w_next;
    logic          r_rx_done_d, r_good;
    logic [7:0]    r_cmd, r_addr, r_data, r_reg_addr, r_reg_wdata, r_tx_data;
    logic [CW-1:0] r_cnt;
    logic          w_acc, w_get, w_to, w_exec_wr, w_exec_rd;
    logic          w_wr_en, w_rd_en, w_tx_start, w_frame_ok, w_err_chk;
    assign w_acc     = bus.rx_done && !r_rx_done_d;
    assign w_get     = r_state inside {GET_CMD, GET_ADDR, GET_DATA, GET_CHK};
    // an accepted byte always beats a timeout landing in the same cycle
    assign w_to      = w_get && !w_acc && r_cnt == CW'(TIMEOUT_CYCLES - 1);
    assign w_exec_wr = r_good && r_cmd == CMD_WR;
    assign w_exec_rd = r_good && r_cmd == CMD_RD;
    always_comb begin
        w_next     = r_state;
        w_wr_en    = 1'b0;
        w_rd_en    = 1'b0;
        w_tx_start = 1'b0;
        w_frame_ok = 1'b0;
        w_err_chk  = 1'b0;
        case (r_state)
            IDLE:     w_next = (w_acc && bus.rx_data == SYNC_BYTE) ? GET_CMD : IDLE;
            GET_CMD:  w_next = w_acc ? GET_ADDR : (w_to ? IDLE : GET_CMD);
            GET_ADDR: w_next = w_acc ? GET_DATA : (w_to ? IDLE : GET_ADDR);
            GET_DATA: w_next = w_acc ? GET_CHK : (w_to ? IDLE : GET_DATA);
            GET_CHK:  w_next = w_acc ? EXEC : (w_to ? IDLE : GET_CHK);
            EXEC: begin
                w_next    = w_exec_rd ? RD_WAIT : SEND;
                w_wr_en   = w_exec_wr;
                w_rd_en   = w_exec_rd;
                w_err_chk = !r_good;
            end
            RD_WAIT:  w_next = SEND;
            SEND: begin
                w_next     = bus.tx_busy ? SEND : IDLE;
                w_tx_start = !bus.tx_busy;
                w_frame_ok = !bus.tx_busy && r_good;
            end
            default:  w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rx_done_d <= 1'b0;
            r_cnt       <= '0;
            r_good      <= 1'b0;
            r_cmd       <= 8'h00;
            r_addr      <= 8'h00;
            r_data      <= 8'h00;
            r_reg_addr  <= 8'h00;
            r_reg_wdata <= 8'h00;
            r_tx_data   <= 8'h00;
        end else begin
            r_state     <= w_next;
            r_rx_done_d <= bus.rx_done;
            r_cnt       <= (w_acc || !w_get || w_to) ? '0 : r_cnt + CW'(1);
            if (w_acc) begin
                case (r_state)
                    GET_CMD:  r_cmd  <= bus.rx_data;
                    GET_ADDR: r_addr <= bus.rx_data;
                    GET_DATA: r_data <= bus.rx_data;
                    GET_CHK: begin
                        r_good      <= bus.rx_data == (r_cmd ^ r_addr ^ r_data)
                                       && (r_cmd == CMD_WR || r_cmd == CMD_RD);
                        r_reg_addr  <= r_addr;
                        r_reg_wdata <= r_data;
                    end
                    default: ;
                endcase
            end
            if (r_state == EXEC && !r_good)
                r_tx_data <= NAK_BYTE;
            else if (r_state == EXEC && r_cmd == CMD_WR)
                r_tx_data <= ACK_BYTE;
            if (r_state == RD_WAIT)
                r_tx_data <= bus.reg_rdata;
        end
    end
    assign bus.reg_addr    = r_reg_addr;
    assign bus.reg_wdata   = r_reg_wdata;
    assign bus.reg_wr_en   = w_wr_en;
    assign bus.reg_rd_en   = w_rd_en;
    assign bus.tx_data     = r_tx_data;
    assign bus.tx_start    = w_tx_start;
    assign bus.frame_ok    = w_frame_ok;
    assign bus.err_chk     = w_err_chk;
    assign bus.err_timeout = w_to;
    assign bus.err_ovr     = w_acc && r_state inside {EXEC, RD_WAIT, SEND};
endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// tb_uart_rx_cmd_ctrl: directed frames with a scoreboard of expected bus/response/error events.
module tb_uart_rx_cmd_ctrl;
    localparam int TO = 200;
    localparam logic [2:0] K_WR = 3'd0, K_RD = 3'd1, K_CHK = 3'd2, K_TX = 3'd3,
                           K_TO = 3'd4, K_OVR = 3'd5, K_FOK = 3'd6;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0, failures = 0, cyc = 0, to_cyc = -1, t_acc = 0, t_mark = 0;
    logic [18:0] q[$];
    uart_rx_cmd_ctrl_if bus();
    uart_rx_cmd_ctrl #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.reg_rdata <= bus.reg_rd_en ? 8'h5A : 8'hEE;
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic send(input logic [7:0] b, input int hold = 1);
        tick();
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        t_acc = cyc;
        tick(hold);
        bus.rx_done = 1'b0;
    endtask
    task automatic frame(input logic [7:0] c, a, d, k, input int hold = 1);
        send(8'hA5, hold);
        send(c, hold);
        send(a, hold);
        send(d, hold);
        send(k, hold);
    endtask
    task automatic push(input logic [2:0] k, input logic [7:0] a = 8'h00, input logic [7:0] b = 8'h00);
        q.push_back({k, a, b});
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic expect_ev(input logic [2:0] k, input logic [7:0] a, input logic [7:0] b);
        logic [18:0] obs, exp;
        obs = {k, a, b};
        if (q.size() != 0) exp = q.pop_front();
        else exp = '1;
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL event observed=%h expected=%h", obs, exp);
        end
    endtask
    always @(negedge clk) begin
        if (bus.reg_wr_en) expect_ev(K_WR, bus.reg_addr, bus.reg_wdata);
        if (bus.reg_rd_en) expect_ev(K_RD, bus.reg_addr, 8'h00);
        if (bus.err_chk) expect_ev(K_CHK, 8'h00, 8'h00);
        if (bus.tx_start) expect_ev(K_TX, bus.tx_data, {7'b0, bus.frame_ok});
        if (bus.frame_ok && !bus.tx_start) expect_ev(K_FOK, 8'h00, 8'h00);
        if (bus.err_timeout) begin
            to_cyc = cyc;
            expect_ev(K_TO, 8'h00, 8'h00);
        end
        if (bus.err_ovr) expect_ev(K_OVR, 8'h00, 8'h00);
    end
    initial begin
        bus.rx_data = 8'h00;
        bus.rx_done = 1'b0;
        bus.tx_busy = 1'b0;
        tick(3);
        chk("reset_addr", bus.reg_addr, 8'h00);
        chk("reset_wdata", bus.reg_wdata, 8'h00);
        chk("reset_tx_data", bus.tx_data, 8'h00);
        chk("reset_strobes", {bus.reg_wr_en, bus.reg_rd_en, bus.tx_start, bus.frame_ok,
                              bus.err_chk, bus.err_timeout, bus.err_ovr}, 0);
        reset = 1'b0;
        tick(2);
        push(K_WR, 8'h10, 8'h3C);
        push(K_TX, 8'h06, 8'h01);
        frame(8'h01, 8'h10, 8'h3C, 8'h2D);
        tick(6);
        chk("write_addr_hold", bus.reg_addr, 8'h10);
        chk("write_wdata_hold", bus.reg_wdata, 8'h3C);
        push(K_RD, 8'h20, 8'h00);
        push(K_TX, 8'h5A, 8'h01);
        frame(8'h02, 8'h20, 8'h00, 8'h22);
        tick(6);
        chk("read_tx_data_hold", bus.tx_data, 8'h5A);
        push(K_CHK);
        push(K_TX, 8'h15, 8'h00);
        frame(8'h01, 8'h10, 8'h3C, 8'h00);
        tick(6);
        push(K_CHK);
        push(K_TX, 8'h15, 8'h00);
        frame(8'h07, 8'h00, 8'h00, 8'h07);
        tick(6);
        push(K_TO);
        send(8'h00);
        send(8'hFF);
        send(8'hA5);
        send(8'h01);
        t_mark = t_acc;
        tick(TO + 20);
        chk("timeout_cycle", to_cyc, t_mark + TO);
        push(K_WR, 8'h55, 8'hAA);
        push(K_TX, 8'h06, 8'h01);
        frame(8'h01, 8'h55, 8'hAA, 8'hFE);
        tick(6);
        bus.tx_busy = 1'b1;
        push(K_WR, 8'h33, 8'h44);
        frame(8'h01, 8'h33, 8'h44, 8'h76, 40);
        tick(3);
        push(K_OVR);
        push(K_TX, 8'h06, 8'h01);
        send(8'h77, 40);
        tick(50);
        chk("busy_pending", q.size(), 1);
        bus.tx_busy = 1'b0;
        tick(6);
        chk("busy_tx_data", bus.tx_data, 8'h06);
        send(8'hA5);
        send(8'h01);
        send(8'h10);
        tick(1);
        reset = 1'b1;
        tick(2);
        chk("midframe_reset_addr", bus.reg_addr, 8'h00);
        chk("midframe_reset_wdata", bus.reg_wdata, 8'h00);
        chk("midframe_reset_tx_data", bus.tx_data, 8'h00);
        reset = 1'b0;
        tick(2);
        push(K_WR, 8'h66, 8'h77);
        push(K_TX, 8'h06, 8'h01);
        frame(8'h01, 8'h66, 8'h77, 8'h10);
        tick(TO + 10);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
